mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, requester/memory address width.
REQ-002 Parameter: DATA_W, default 32, data width.
REQ-003 Parameter: DEPTH, default 32, memory depth in words; valid byte addresses are 0 .. 4*DEPTH-1.
REQ-004 Port: clock  in  1  single clock; all state changes on posedge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Ports per requester N in {0,1}: reqN in 1 request; weN in 1 (1 = write, 0 = read); addrN in ADDR_W byte address; wdataN in DATA_W write data.
REQ-007 Ports per requester N: ackN out 1 one-cycle completion pulse; errN out 1 out-of-range flag, valid with ackN; rdataN out DATA_W read data, valid with ackN.
REQ-008 Memory side: mem_address out ADDR_W; mem_writedata out DATA_W; mem_memread out 1; mem_memwrite out 1; mem_readdata in DATA_W.
REQ-009 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-010 States: IDLE, ISSUE, RESP; a state register is the only sequencing element.
REQ-011 IDLE: with no reqN high, remain in IDLE and hold all mem strobes low.
REQ-012 IDLE, exactly one reqN high: grant that port, latch its we/addr/wdata, go to ISSUE.
REQ-013 IDLE, both req high: grant the port not recorded in last_grant (round-robin), then update last_grant to the granted port.
REQ-014 ISSUE (one cycle): drive mem_address/mem_writedata from the latched values; assert exactly one of mem_memread/mem_memwrite per the latched we; go to RESP.
REQ-015 ISSUE with an out-of-range address (addr >= 4*DEPTH): hold both strobes low; the access is not issued to memory.
REQ-016 RESP (one cycle): pulse ackN for the granted port only; rdataN = mem_readdata for reads, 0 for writes and errors; errN = 1 only for out-of-range; go to IDLE.
REQ-017 Latency: req sampled in IDLE at edge k -> strobes during cycle k+1 -> ack during cycle k+2; back-to-back throughput is one access per 3 cycles.
REQ-018 The requester holds reqN, weN, addrN and wdataN stable until it sees ackN; changes to reqN while not granted have no effect on an access in progress.
REQ-019 mem_memread and mem_memwrite are never high together; strobes are low in IDLE and RESP.
REQ-020 Non-granted ackN and errN stay 0; rdataN of the non-granted port is 0.
REQ-021 addr[1:0] are forwarded unmodified; word selection is done by the memory.

Reset
REQ-022 reset_n low forces immediately: state = IDLE, last_grant = 1 (port 0 wins the first tie), all strobes/ack/err/busy = 0, rdata = 0.
REQ-023 Reset asserted mid-ISSUE/RESP aborts the access with no ack; after release the arbiter re-arbitrates from IDLE.

Structure
REQ-024 Shared package mem_arb_pkg holds the state enum (IDLE, ISSUE, RESP) and the default DEPTH/ADDR_W/DATA_W constants.
REQ-025 The grant decision lives in the sub-module rr_pick2 (inputs req0, req1, last_grant; output grant index, valid); everything else lives in mem_arbiter.

Verification
REQ-026 Single read: req0=1, we0=0, addr0=4, memory word1=1000 -> mem_memread high for 1 cycle at addr 4; ack0 two cycles after sample with rdata0=1000, err0=0.
REQ-027 Write then read: port1 writes 0xDEAD_BEEF to addr 8, then reads addr 8 -> mem_memwrite for one cycle, ack1; the read returns 0xDEADBEEF.
REQ-028 Contention: req0 and req1 held continuously after reset -> grants alternate 0,1,0,1; each ack is 3 cycles apart.
REQ-029 Out of range: req0 read at addr 128 (DEPTH=32) -> no strobe; ack0=1, err0=1, rdata0=0.
REQ-030 Reset in ISSUE: drop reset_n while mem_memwrite is high -> strobe falls without waiting for a clock; no ack; first request after release completes normally.
REQ-031 Every scenario checks: strobes are never both high, ack is one cycle wide, and busy matches state != IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and default sizing for the two-port memory arbiter
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory bus bundle for mem_arbiter
//   reqN/weN/addrN/wdataN : requester N command (held until ackN)
//   ackN/errN/rdataN      : requester N one-cycle completion, range error, read data
//   mem_*                 : single-cycle memory strobe interface
//   busy                  : arbiter not idle
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              req0, we0, ack0, err0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic              req1, we1, ack1, err1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic              mem_memread, mem_memwrite;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_readdata,
        output ack0, err0, rdata0, ack1, err1, rdata1,
        output mem_address, mem_writedata, mem_memread, mem_memwrite, busy
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_readdata,
        input  ack0, err0, rdata0, ack1, err1, rdata1,
        input  mem_address, mem_writedata, mem_memread, mem_memwrite, busy
    );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin grant decision
//   req0/req1  : pending requests
//   last_grant : port granted on the previous tie
//   grant      : chosen port index, valid when any request is pending
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);
    always_comb begin
        valid = req0 | req1;
        grant = (req0 && req1) ? ~last_grant : req1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory between two requesters
//   clock   : single clock, all state changes on posedge
//   reset_n : asynchronous active-low reset
//   bus     : requester ports 0/1 plus memory strobe side (mem_arbiter_if.slave)
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    // One extra bit so 4*DEPTH never wraps for narrow address widths
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH);

    state_t            state;
    logic              last_grant, gnt, we_q, oor_q;
    logic              pick, pick_valid;
    logic              sel_we, sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    always_comb begin
        sel_we    = pick ? bus.we1 : bus.we0;
        sel_addr  = pick ? bus.addr1 : bus.addr0;
        sel_wdata = pick ? bus.wdata1 : bus.wdata0;
        sel_oor   = {1'b0, sel_addr} >= LIMIT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            last_grant        <= 1'b1;
            gnt               <= 1'b0;
            we_q              <= 1'b0;
            oor_q             <= 1'b0;
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
            bus.mem_memread   <= 1'b0;
            bus.mem_memwrite  <= 1'b0;
            bus.ack0          <= 1'b0;
            bus.ack1          <= 1'b0;
            bus.err0          <= 1'b0;
            bus.err1          <= 1'b0;
            bus.rdata0        <= '0;
            bus.rdata1        <= '0;
            bus.busy          <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses; RESP entry re-raises them
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.err0   <= 1'b0;
            bus.err1   <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state             <= ISSUE;
                        bus.busy          <= 1'b1;
                        gnt               <= pick;
                        if (bus.req0 && bus.req1) last_grant <= pick;
                        we_q              <= sel_we;
                        oor_q             <= sel_oor;
                        bus.mem_address   <= sel_addr;
                        bus.mem_writedata <= sel_wdata;
                        bus.mem_memread   <= !sel_we && !sel_oor;
                        bus.mem_memwrite  <= sel_we && !sel_oor;
                    end
                end
                ISSUE: begin
                    state            <= RESP;
                    bus.mem_memread  <= 1'b0;
                    bus.mem_memwrite <= 1'b0;
                    bus.ack0         <= !gnt;
                    bus.ack1         <= gnt;
                    bus.err0         <= !gnt && oor_q;
                    bus.err1         <= gnt && oor_q;
                    // Memory read data is combinational on mem_address during ISSUE
                    bus.rdata0       <= (!gnt && !we_q && !oor_q) ? bus.mem_readdata : '0;
                    bus.rdata1       <= (gnt && !we_q && !oor_q) ? bus.mem_readdata : '0;
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a 32-word memory model
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:31];
    bit          mem_loaded = 1'b0;

    assign bus.mem_readdata = mem[bus.mem_address[6:2]];

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
            mem[0]     <= 32'd11;
            mem[1]     <= 32'd1000;
            mem[3]     <= 32'd33;
            mem[4]     <= 32'd44;
            mem[31]    <= 32'h31;
            mem_loaded <= 1'b1;
        end else if (bus.mem_memwrite) begin
            mem[bus.mem_address[6:2]] <= bus.mem_writedata;
        end
    end

    logic prev_ack0 = 1'b0;
    logic prev_ack1 = 1'b0;

    always @(negedge clock) begin
        vectors += 2;
        if (bus.mem_memread && bus.mem_memwrite) begin
            miscompares++;
            $display("FAIL strobe_excl: memread=%0b memwrite=%0b, required not both high", bus.mem_memread, bus.mem_memwrite);
        end
        if ((bus.ack0 && prev_ack0) || (bus.ack1 && prev_ack1)) begin
            miscompares++;
            $display("FAIL ack_width: ack0=%0b ack1=%0b high two cycles, required one", bus.ack0, bus.ack1);
        end
        prev_ack0 = bus.ack0;
        prev_ack1 = bus.ack1;
    end

    task automatic step;
        @(negedge clock);
    endtask

    task automatic test_reset;
        step();
        vectors += 6;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        if (bus.mem_memread !== 1'b0) begin miscompares++; $display("FAIL rst_memread: got %0b want 0", bus.mem_memread); end
        if (bus.mem_memwrite !== 1'b0) begin miscompares++; $display("FAIL rst_memwrite: got %0b want 0", bus.mem_memwrite); end
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %0b%0b want 00", bus.ack0, bus.ack1); end
        if (bus.err0 !== 1'b0 || bus.err1 !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %0b%0b want 00", bus.err0, bus.err1); end
        if (bus.rdata0 !== 32'd0 || bus.rdata1 !== 32'd0) begin miscompares++; $display("FAIL rst_rdata: got %h/%h want 0", bus.rdata0, bus.rdata1); end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_single_read;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd4;
        step();
        vectors += 4;
        if (bus.mem_memread !== 1'b1) begin miscompares++; $display("FAIL rd_memread: got %0b want 1", bus.mem_memread); end
        if (bus.mem_memwrite !== 1'b0) begin miscompares++; $display("FAIL rd_memwrite: got %0b want 0", bus.mem_memwrite); end
        if (bus.mem_address !== 32'd4) begin miscompares++; $display("FAIL rd_address: got %0d want 4", bus.mem_address); end
        if (bus.busy !== 1'b1 || bus.ack0 !== 1'b0) begin miscompares++; $display("FAIL rd_issue: busy=%0b ack0=%0b want 1/0", bus.busy, bus.ack0); end
        step();
        vectors += 5;
        if (bus.ack0 !== 1'b1) begin miscompares++; $display("FAIL rd_ack0: got %0b want 1", bus.ack0); end
        if (bus.rdata0 !== 32'd1000) begin miscompares++; $display("FAIL rd_rdata0: got %0d want 1000", bus.rdata0); end
        if (bus.err0 !== 1'b0) begin miscompares++; $display("FAIL rd_err0: got %0b want 0", bus.err0); end
        if (bus.ack1 !== 1'b0 || bus.rdata1 !== 32'd0) begin miscompares++; $display("FAIL rd_port1: ack1=%0b rdata1=%h want 0/0", bus.ack1, bus.rdata1); end
        if (bus.mem_memread !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL rd_resp: memread=%0b busy=%0b want 0/1", bus.mem_memread, bus.busy); end
        bus.req0 = 1'b0;
        step();
        vectors += 1;
        if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0) begin miscompares++; $display("FAIL rd_idle: busy=%0b ack0=%0b want 0/0", bus.busy, bus.ack0); end
    endtask

    task automatic test_write_read;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'd8; bus.wdata1 = 32'hDEAD_BEEF;
        step();
        vectors += 3;
        if (bus.mem_memwrite !== 1'b1 || bus.mem_memread !== 1'b0) begin miscompares++; $display("FAIL wr_strobe: memwrite=%0b memread=%0b want 1/0", bus.mem_memwrite, bus.mem_memread); end
        if (bus.mem_address !== 32'd8) begin miscompares++; $display("FAIL wr_address: got %0d want 8", bus.mem_address); end
        if (bus.mem_writedata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_wdata: got %h want deadbeef", bus.mem_writedata); end
        step();
        vectors += 3;
        if (bus.ack1 !== 1'b1 || bus.err1 !== 1'b0) begin miscompares++; $display("FAIL wr_ack1: ack1=%0b err1=%0b want 1/0", bus.ack1, bus.err1); end
        if (bus.rdata1 !== 32'd0) begin miscompares++; $display("FAIL wr_rdata1: got %h want 0", bus.rdata1); end
        if (bus.ack0 !== 1'b0) begin miscompares++; $display("FAIL wr_ack0: got %0b want 0", bus.ack0); end
        bus.we1 = 1'b0;
        step();
        vectors += 1;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL wr_idle_busy: got %0b want 0", bus.busy); end
        step();
        vectors += 1;
        if (bus.mem_memread !== 1'b1 || bus.mem_address !== 32'd8) begin miscompares++; $display("FAIL rb_issue: memread=%0b addr=%0d want 1/8", bus.mem_memread, bus.mem_address); end
        step();
        vectors += 2;
        if (bus.ack1 !== 1'b1) begin miscompares++; $display("FAIL rb_ack1: got %0b want 1", bus.ack1); end
        if (bus.rdata1 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rb_rdata1: got %h want deadbeef", bus.rdata1); end
        bus.req1 = 1'b0;
        step();
    endtask

    task automatic test_contention;
        reset_n = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd12;
        step();
        reset_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            vectors += 4;
            if (bus.ack0 !== (c % 6 == 2)) begin miscompares++; $display("FAIL rr_ack0 c%0d: got %0b want %0b", c, bus.ack0, c % 6 == 2); end
            if (bus.ack1 !== (c % 6 == 5)) begin miscompares++; $display("FAIL rr_ack1 c%0d: got %0b want %0b", c, bus.ack1, c % 6 == 5); end
            if (bus.busy !== (c % 3 != 0)) begin miscompares++; $display("FAIL rr_busy c%0d: got %0b want %0b", c, bus.busy, c % 3 != 0); end
            if (bus.mem_memread !== (c % 3 == 1)) begin miscompares++; $display("FAIL rr_memread c%0d: got %0b want %0b", c, bus.mem_memread, c % 3 == 1); end
            if (c % 6 == 1) begin
                vectors++;
                if (bus.mem_address !== 32'd0) begin miscompares++; $display("FAIL rr_addr0 c%0d: got %0d want 0", c, bus.mem_address); end
            end
            if (c % 6 == 4) begin
                vectors++;
                if (bus.mem_address !== 32'd12) begin miscompares++; $display("FAIL rr_addr1 c%0d: got %0d want 12", c, bus.mem_address); end
            end
            if (c % 6 == 2) begin
                vectors++;
                if (bus.rdata0 !== 32'd11 || bus.rdata1 !== 32'd0) begin miscompares++; $display("FAIL rr_rdata0 c%0d: got %0d/%0d want 11/0", c, bus.rdata0, bus.rdata1); end
            end
            if (c % 6 == 5) begin
                vectors++;
                if (bus.rdata1 !== 32'd33 || bus.rdata0 !== 32'd0) begin miscompares++; $display("FAIL rr_rdata1 c%0d: got %0d/%0d want 33/0", c, bus.rdata1, bus.rdata0); end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
    endtask

    task automatic test_out_of_range;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd128;
        step();
        vectors += 2;
        if (bus.mem_memread !== 1'b0 || bus.mem_memwrite !== 1'b0) begin miscompares++; $display("FAIL oor_strobe: memread=%0b memwrite=%0b want 0/0", bus.mem_memread, bus.mem_memwrite); end
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL oor_busy: got %0b want 1", bus.busy); end
        step();
        vectors += 3;
        if (bus.ack0 !== 1'b1 || bus.err0 !== 1'b1) begin miscompares++; $display("FAIL oor_ack: ack0=%0b err0=%0b want 1/1", bus.ack0, bus.err0); end
        if (bus.rdata0 !== 32'd0) begin miscompares++; $display("FAIL oor_rdata0: got %h want 0", bus.rdata0); end
        if (bus.err1 !== 1'b0) begin miscompares++; $display("FAIL oor_err1: got %0b want 0", bus.err1); end
        bus.req0 = 1'b0;
        step();
        bus.req0 = 1'b1; bus.addr0 = 32'd124;
        step();
        vectors += 1;
        if (bus.mem_memread !== 1'b1) begin miscompares++; $display("FAIL edge_memread: got %0b want 1", bus.mem_memread); end
        step();
        vectors += 2;
        if (bus.ack0 !== 1'b1 || bus.err0 !== 1'b0) begin miscompares++; $display("FAIL edge_ack: ack0=%0b err0=%0b want 1/0", bus.ack0, bus.err0); end
        if (bus.rdata0 !== 32'h31) begin miscompares++; $display("FAIL edge_rdata0: got %h want 31", bus.rdata0); end
        bus.req0 = 1'b0;
        step();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd200; bus.wdata0 = 32'hBAD;
        step();
        vectors += 1;
        if (bus.mem_memwrite !== 1'b0) begin miscompares++; $display("FAIL oorw_memwrite: got %0b want 0", bus.mem_memwrite); end
        step();
        vectors += 2;
        if (bus.ack0 !== 1'b1 || bus.err0 !== 1'b1) begin miscompares++; $display("FAIL oorw_ack: ack0=%0b err0=%0b want 1/1", bus.ack0, bus.err0); end
        if (mem[18] !== 32'd18) begin miscompares++; $display("FAIL oorw_mem18: got %h want 12", mem[18]); end
        bus.req0 = 1'b0;
        step();
    endtask

    task automatic test_reset_in_issue;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd16; bus.wdata0 = 32'h55;
        step();
        vectors += 1;
        if (bus.mem_memwrite !== 1'b1) begin miscompares++; $display("FAIL rii_pre: memwrite=%0b want 1", bus.mem_memwrite); end
        #1 reset_n = 1'b0;
        #1;
        vectors += 2;
        if (bus.mem_memwrite !== 1'b0) begin miscompares++; $display("FAIL rii_async: memwrite=%0b want 0", bus.mem_memwrite); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rii_busy: got %0b want 0", bus.busy); end
        step();
        vectors += 2;
        if (bus.ack0 !== 1'b0) begin miscompares++; $display("FAIL rii_noack: got %0b want 0", bus.ack0); end
        if (mem[4] !== 32'd44) begin miscompares++; $display("FAIL rii_mem4: got %h want 2c", mem[4]); end
        bus.we0 = 1'b0; bus.addr0 = 32'd4;
        reset_n = 1'b1;
        step();
        vectors += 1;
        if (bus.mem_memread !== 1'b1 || bus.mem_address !== 32'd4) begin miscompares++; $display("FAIL rii_issue: memread=%0b addr=%0d want 1/4", bus.mem_memread, bus.mem_address); end
        step();
        vectors += 1;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'd1000) begin miscompares++; $display("FAIL rii_done: ack0=%0b rdata0=%0d want 1/1000", bus.ack0, bus.rdata0); end
        bus.req0 = 1'b0;
        step();
    endtask

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_in_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
